// File: rtl/gat_bram_loader.sv
// Streams 32-bit source beats into BRAM port A at consecutive word addresses.
// Signals completion with a level load_done and flags length mismatches.
module gat_bram_loader #(
  parameter int unsigned DEPTH  = 242101,
  parameter int unsigned ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-3:0] num_words,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [31:0]       bram_din,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic              load_done,
  output logic              busy,
  output logic              len_err
);

  localparam int unsigned CNT_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] num_words_q;
  logic             final_beat_c;

  assign s_ready      = (state == LOAD);
  assign busy         = (state == LOAD);
  assign final_beat_c = (word_cnt == num_words_q - CNT_W'(1));

  // FLUSH gives the last write one cycle to commit before load_done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      num_words_q <= '0;
      bram_din    <= '0;
      bram_ena    <= 1'b0;
      bram_wea    <= 1'b0;
      bram_addra  <= '0;
      load_done   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      bram_ena <= 1'b0;
      bram_wea <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_words_q <= num_words;
            word_cnt    <= '0;
            load_done   <= 1'b0;
            len_err     <= 1'b0;
            state       <= (num_words == '0) ? FLUSH : LOAD;
          end
        end
        LOAD: begin
          if (s_valid) begin
            bram_ena   <= 1'b1;
            bram_wea   <= 1'b1;
            bram_din   <= s_data;
            bram_addra <= {word_cnt, 2'b00};
            word_cnt   <= word_cnt + CNT_W'(1);
            if (final_beat_c) begin
              state <= FLUSH;
              if (!s_last) len_err <= 1'b1;
            end else if (s_last) begin
              state   <= FLUSH;
              len_err <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state     <= DONE;
          load_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader; expected BRAM writes are queued when
// beats are driven and popped as write cycles appear on port A.
module tb_gat_bram_loader;

  localparam int unsigned AW = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-3:0] num_words;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic [31:0]   bram_din;
  logic          bram_ena;
  logic          bram_wea;
  logic [AW-1:0] bram_addra;
  logic          load_done;
  logic          busy;
  logic          len_err;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  gat_bram_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .bram_din(bram_din), .bram_ena(bram_ena), .bram_wea(bram_wea),
    .bram_addra(bram_addra), .load_done(load_done), .busy(busy),
    .len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: let the edge happen, then compare any write against the scoreboard.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    @(negedge clk);
    chk("wea_eq_ena", 32'(bram_wea), 32'(bram_ena));
    if (bram_ena) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("write_addr", 32'(bram_addra), 32'(w.addr));
        chk("write_data", bram_din, w.data);
      end
    end
  endtask

  task automatic do_start(input logic [AW-3:0] n);
    start = 1'b1; num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic expect_acc,
                      input logic [AW-1:0] addr);
    s_valid = 1'b1; s_data = d; s_last = last;
    if (expect_acc) exp_q.push_back('{addr: addr, data: d});
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_ena", 32'(bram_ena), 0);
    chk("rst_din", bram_din, 0);
    chk("rst_addra", 32'(bram_addra), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_len_err", 32'(len_err), 0);
    rst = 1'b0;
    tick();

    // Basic back-to-back load of four words
    do_start(18'd4);
    chk("basic_busy", 32'(busy), 1);
    chk("basic_s_ready", 32'(s_ready), 1);
    for (int i = 0; i < 4; i++)
      beat(32'hA0 + 32'(i), i == 3, 1'b1, AW'(4 * i));
    chk("basic_flush_done", 32'(load_done), 0);
    chk("basic_flush_busy", 32'(busy), 0);
    idle_cycle();
    chk("basic_done", 32'(load_done), 1);
    chk("basic_len_err", 32'(len_err), 0);
    chk("basic_addr_hold", 32'(bram_addra), 32'hC);
    chk("basic_din_hold", bram_din, 32'hA3);
    chk("basic_q_empty", 32'(exp_q.size()), 0);

    // Gapped source, restarted from DONE
    do_start(18'd3);
    chk("gap_done_drop", 32'(load_done), 0);
    beat(32'hB0, 1'b0, 1'b1, AW'(0));
    idle_cycle();
    beat(32'hB1, 1'b0, 1'b1, AW'(4));
    idle_cycle();
    beat(32'hB2, 1'b1, 1'b1, AW'(8));
    idle_cycle();
    chk("gap_done", 32'(load_done), 1);
    chk("gap_len_err", 32'(len_err), 0);
    chk("gap_q_empty", 32'(exp_q.size()), 0);

    // Early s_last terminates the load
    do_start(18'd5);
    beat(32'hC0, 1'b0, 1'b1, AW'(0));
    beat(32'hC1, 1'b1, 1'b1, AW'(4));
    chk("early_s_ready_flush", 32'(s_ready), 0);
    idle_cycle();
    chk("early_done", 32'(load_done), 1);
    chk("early_len_err", 32'(len_err), 1);
    beat(32'hC2, 1'b0, 1'b0, AW'(0));
    chk("early_s_ready_after", 32'(s_ready), 0);
    chk("early_q_empty", 32'(exp_q.size()), 0);

    // Missing s_last: extra beat is refused
    do_start(18'd2);
    chk("miss_len_err_cleared", 32'(len_err), 0);
    beat(32'hD0, 1'b0, 1'b1, AW'(0));
    beat(32'hD1, 1'b0, 1'b1, AW'(4));
    beat(32'hD2, 1'b0, 1'b0, AW'(0));
    beat(32'hD3, 1'b1, 1'b0, AW'(0));
    chk("miss_len_err", 32'(len_err), 1);
    chk("miss_done", 32'(load_done), 1);
    chk("miss_q_empty", 32'(exp_q.size()), 0);

    // Zero length, then a one-word restart from DONE
    do_start(18'd0);
    chk("zero_flush_busy", 32'(busy), 0);
    chk("zero_flush_done", 32'(load_done), 0);
    chk("zero_len_err", 32'(len_err), 0);
    idle_cycle();
    chk("zero_done", 32'(load_done), 1);
    do_start(18'd1);
    chk("one_done_drop", 32'(load_done), 0);
    chk("one_busy", 32'(busy), 1);
    beat(32'hE0, 1'b1, 1'b1, AW'(0));
    idle_cycle();
    chk("one_done", 32'(load_done), 1);
    chk("one_len_err", 32'(len_err), 0);

    // Reset mid-load wins over start and the handshake
    do_start(18'd6);
    beat(32'hF0, 1'b0, 1'b1, AW'(0));
    beat(32'hF1, 1'b0, 1'b1, AW'(4));
    rst = 1'b1; start = 1'b1; num_words = 18'd3;
    s_valid = 1'b1; s_data = 32'hF2;
    tick();
    chk("rst_mid_ena", 32'(bram_ena), 0);
    chk("rst_mid_din", bram_din, 0);
    chk("rst_mid_addra", 32'(bram_addra), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_s_ready", 32'(s_ready), 0);
    tick();
    chk("rst_hold_busy", 32'(busy), 0);
    chk("rst_hold_done", 32'(load_done), 0);
    rst = 1'b0; start = 1'b0;
    s_valid = 1'b1; s_data = 32'hF3;
    tick();
    tick();
    s_valid = 1'b0;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_done", 32'(load_done), 0);
    chk("post_rst_len_err", 32'(len_err), 0);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
